// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, line levels and
// parity-type encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_type_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity bit for a latched UART data word.
// Even parity makes the total count of ones even; odd makes it odd.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  parity_type,
  output logic                  parity_bit
);

  always_comb begin
    parity_bit = ^data;
    if (parity_type == PARITY_ODD) parity_bit = ~^data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop bit.
// One bit per clock; TX_out and busy are both registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  parity_type,
  input  logic                  parity_enable,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  TX_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ptype_q, pen_q;
  logic                  tx_d, busy_d, load;
  logic                  parity_bit;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data       (data_q),
    .parity_type(ptype_q),
    .parity_bit (parity_bit)
  );

  // Next-state logic also produces the next line level so TX_out is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = IDLE_LEVEL;
    busy_d  = 1'b1;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (data_valid) begin
          load    = 1'b1;
          shift_d = parallel_data;
          cnt_d   = '0;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (pen_q) begin
            tx_d    = parity_bit;
            state_d = PARITY;
          end else begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        tx_d    = STOP_BIT;
        state_d = STOP;
      end
      STOP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ptype_q <= 1'b0;
      pen_q   <= 1'b0;
      TX_out  <= IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      TX_out  <= tx_d;
      busy    <= busy_d;
      // Frame configuration is frozen at acceptance.
      if (load) begin
        data_q  <= parallel_data;
        ptype_q <= parity_type;
        pen_q   <= parity_enable;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames
// compared against a bit-list frame model.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       parity_type;
  logic       parity_enable;
  logic       data_valid;
  logic [7:0] parallel_data;
  logic       TX_out;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  bit exp_q[$];

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .parity_type  (parity_type),
    .parity_enable(parity_enable),
    .data_valid   (data_valid),
    .parallel_data(parallel_data),
    .TX_out       (TX_out),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame as a list of line levels, one entry per bit period.
  task automatic build_frame(input logic [7:0] d, input logic odd, input logic pen);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pen) exp_q.push_back(odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    exp_q.push_back(1'b1);
  endtask

  // Called just after a negedge with the line idle. pulse_at >= 1 raises a
  // one-cycle data_valid (data 0x55) in the middle of the frame.
  task automatic send_frame(input string name, input logic [7:0] d, input logic odd,
                            input logic pen, input int pulse_at, input int idle_after);
    int len;
    build_frame(d, odd, pen);
    len = exp_q.size();
    parallel_data = d;
    parity_type   = odd;
    parity_enable = pen;
    data_valid    = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s_tx%0d", name, i), TX_out, exp_q[i]);
      check($sformatf("%s_busy%0d", name, i), busy, 1'b1);
      data_valid    = (i == pulse_at);
      parallel_data = (i == pulse_at) ? 8'h55 : 8'($urandom);
      parity_type   = 1'($urandom);
      parity_enable = 1'($urandom);
    end
    @(negedge clk);
    data_valid = 1'b0;
    check({name, "_end_tx"}, TX_out, 1'b1);
    check({name, "_end_busy"}, busy, 1'b0);
    for (int i = 0; i < idle_after; i++) begin
      @(negedge clk);
      check({name, "_gap_tx"}, TX_out, 1'b1);
      check({name, "_gap_busy"}, busy, 1'b0);
    end
  endtask

  initial begin
    reset         = 1'b0;
    data_valid    = 1'b0;
    parallel_data = 8'h00;
    parity_type   = 1'b0;
    parity_enable = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_tx", TX_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", TX_out, 1'b1);
      check("idle_busy", busy, 1'b0);
    end

    send_frame("even_e6", 8'hE6, 1'b0, 1'b1, -1, 0);
    send_frame("odd_ff", 8'hFF, 1'b1, 1'b1, -1, 1);
    send_frame("nopar_f4", 8'hF4, 1'b0, 1'b0, -1, 1);
    send_frame("pulse_mid", 8'h3C, 1'b0, 1'b1, 4, 2);
    send_frame("pulse_stop", 8'h81, 1'b1, 1'b0, 9, 2);

    // Reset while in the DATA state must clear outputs without a clock edge.
    build_frame(8'h5A, 1'b0, 1'b1);
    parallel_data = 8'h5A;
    parity_type   = 1'b0;
    parity_enable = 1'b1;
    data_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("prerst_tx%0d", i), TX_out, exp_q[i]);
      data_valid = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", TX_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    check("midrst_hold_tx", TX_out, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_busy", busy, 1'b0);
    send_frame("after_rst_a5", 8'hA5, 1'b0, 1'b1, -1, 0);

    for (int k = 0; k < 30; k++) begin
      int pulse;
      pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
      send_frame($sformatf("rnd%0d", k), 8'($urandom), 1'($urandom), 1'($urandom),
                 pulse, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised UART serializer: accepts one parallel word on a valid strobe and shifts it out as a frame.
- Frame format: start bit (0), data LSB-first, optional parity bit, stop bit (1).
- One bit is sent per clock cycle; the clock is the baud-rate tick, and any baud division happens upstream.
- Sits at the TX side of the UART, fed by the system controller/FIFO; drives the serial line and a busy flag.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  bit-rate clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- parity_type  input  1  0 = even parity, 1 = odd parity.
- parity_enable  input  1  1 = insert a parity bit between the data and the stop bit.
- data_valid  input  1  one-cycle strobe: parallel_data is valid; accepted only when idle.
- parallel_data  input  DATA_WIDTH  word to transmit.
- TX_out  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is in progress, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, TX_out = 1, busy = 0, internal data/config registers cleared.
  - Reset mid-frame aborts the frame immediately, and the line returns high.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_out = 1, busy = 0.
  - At a rising edge with data_valid = 1: latch parallel_data, parity_type and parity_enable; drive TX_out = 0 (start bit); set busy = 1; go to START.
  - The start bit therefore appears on TX_out from the accepting edge, so sampling one period later reads 0.
- START → DATA on the next edge; TX_out = data[0].
- DATA: each edge shifts out the next bit, data[1] .. data[DATA_WIDTH-1], LSB first; a bit counter 0..DATA_WIDTH-1 is cleared on accept.
  - After the last data bit: if the latched parity_enable = 1, go to PARITY with TX_out = parity bit.
  - Otherwise go to STOP with TX_out = 1.
- Parity bit: XOR-reduce of the latched data when parity_type = 0 (even); XNOR-reduce when parity_type = 1 (odd).
- PARITY → STOP; TX_out = 1 for one cycle.
- STOP → IDLE on the next edge; TX_out stays 1 and busy = 0 from that edge.
- Frame length: DATA_WIDTH + 3 cycles with parity, DATA_WIDTH + 2 without. The stop bit is exactly one cycle.
- busy is high from the accepting edge until the edge that enters IDLE.
- data_valid while busy = 1 (including during STOP) is ignored; no queuing.
- A new frame may be accepted on the first edge after returning to IDLE: minimum one idle cycle between frames.
- Changes to the inputs during a frame have no effect on that frame, because they are latched at acceptance.
- There is no X-propagation path: every register has a reset value.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT = 0, STOP_BIT = 1, IDLE_LEVEL = 1;
  - parity-type encodings PARITY_EVEN = 0, PARITY_ODD = 1.
- One natural sub-module: uart_tx_parity_calc (combinational parity from latched data and parity_type).
- The FSM, bit counter, shift register and output mux stay in uart_tx.

Test Plan:
- Even parity, parity_enable = 1, parallel_data = 0xE6, one-cycle data_valid:
  - Sampled per cycle, TX_out = 0, then 0,1,1,0,0,1,1,1 (LSB first), then parity 1, then stop 1.
  - 11-bit frame {1,1,0xE6,0}; busy high for 11 cycles.
- Odd parity, parity_enable = 1, data = 0xFF, sent one idle cycle after the previous frame:
  - Frame = {stop 1, parity 1, 0xFF, start 0}.
- parity_enable = 0, data = 0xF4:
  - 10-bit frame {1, 0xF4, 0}; no parity slot.
  - Line is high and busy = 0 on the following cycle.
- data_valid pulsed mid-frame with data 0x55: ignored; the current frame completes unchanged and no second frame starts.
- Reset asserted during the DATA state:
  - TX_out = 1 and busy = 0 immediately, without waiting for a clock.
  - After release, a new 0xA5 frame transmits correctly.
- Idle after reset with no data_valid for 20 cycles: TX_out constantly 1, busy constantly 0.
